// File: rtl/video_pkg.sv
// ----------------------------------------------------------------------------
// video_pkg
// Shared constants and types for the video adapter I/O register block.
//   - Port offsets relative to the I/O base (mode control, colour select,
//     status / index, indexed data).
//   - Indexed register numbers with side effects (border, mode select,
//     palette window start/end).
//   - Mode control register reset value.
//   - Wait-state FSM state encoding.
//   - is_pal_reg(): true when an index selects the palette window.
// ----------------------------------------------------------------------------
package video_pkg;

    localparam logic [3:0] OFS_CTRL    = 4'h8;
    localparam logic [3:0] OFS_COLOR   = 4'h9;
    localparam logic [3:0] OFS_STATUS  = 4'hA;
    localparam logic [3:0] OFS_IDXDATA = 4'hE;

    localparam logic [7:0] REG_BORDER   = 8'd2;
    localparam logic [7:0] REG_MODESEL  = 8'd3;
    localparam logic [7:0] REG_PAL_BASE = 8'd16;
    localparam logic [7:0] REG_PAL_LAST = 8'd31;

    localparam logic [7:0] CTRL_RESET = 8'h29;

    typedef enum logic [1:0] {
        WS_IDLE = 2'd0,
        WS_WAIT = 2'd1,
        WS_HOLD = 2'd2
    } wait_state_t;

    function automatic logic is_pal_reg(input logic [7:0] idx);
        return (idx >= REG_PAL_BASE) && (idx <= REG_PAL_LAST);
    endfunction

endpackage

// File: rtl/video_bus_wait.sv
// ----------------------------------------------------------------------------
// video_bus_wait
// ISA wait-state generator. Holds bus_rdy low for WAIT_CYCLES clocks after a
// decoded access starts, then waits in HOLD until both synchronised strobes
// are released before accepting the next access.
// Ports:
//   clk, reset_l   video clock, asynchronous active-low reset
//   start          one-clock pulse: decoded strobe falling edge seen
//   strobes_idle   both synchronised strobes are high
//   bus_rdy        ISA ready (forced high when USE_BUS_WAIT == 0)
//   state          current FSM state, exported for observation
// ----------------------------------------------------------------------------
module video_bus_wait
    import video_pkg::*;
#(
    parameter int USE_BUS_WAIT = 0,
    parameter int WAIT_CYCLES  = 4
)(
    input  logic        clk,
    input  logic        reset_l,
    input  logic        start,
    input  logic        strobes_idle,
    output logic        bus_rdy,
    output wait_state_t state
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    wait_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= WS_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WS_IDLE: begin
                if (start) begin
                    state_d = WS_WAIT;
                    cnt_d   = 4'd0;
                end
            end
            WS_WAIT: begin
                // Count runs to completion even if the host lets go early.
                if (cnt_q == LAST_CNT) begin
                    state_d = WS_HOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WS_HOLD: begin
                if (strobes_idle) begin
                    state_d = WS_IDLE;
                end
            end
            default: state_d = WS_IDLE;
        endcase
    end

    assign bus_rdy = (USE_BUS_WAIT == 0) || (state_q != WS_WAIT);
    assign state   = state_q;

endmodule

// File: rtl/video_ioregs.sv
// ----------------------------------------------------------------------------
// video_ioregs
// ISA I/O register block for CGA / Tandy / MDA-style video adapters.
// Decodes port accesses at IO_BASE_ADDR, holds mode control and colour select
// registers plus a Tandy-style indexed register file, pulses palette writes to
// the pixel pipeline, generates wait states and the blink phase.
//
// Bus handshake: an access begins when a synchronised I/O strobe falls while
// the address decodes (aen low, hw_en high). A write takes effect on the one
// clock where the synchronised bus_iow_l goes 1->0, sampling bus_a/bus_d that
// cycle. Reads are combinational from the raw bus_ior_l. While bus_rdy is low
// the host must stretch the bus cycle; a new access is only recognised after
// both strobes have been seen high again.
//
// Ports:
//   clk, reset_l              video clock, asynchronous active-low reset
//   bus_a, bus_d              ISA address (15) and write data (8)
//   bus_ior_l, bus_iow_l      ISA I/O strobes, asynchronous to clk
//   bus_aen, hw_en            decode qualifiers
//   vsync_l, display_enable   CRTC status sources for the status port
//   splashscreen              freezes the blink counter
//   bus_out, bus_dir          read data and drive enable
//   bus_rdy                   ISA ready
//   control_reg, color_reg    mode control (base+8), colour select (base+9)
//   border_color, mode_sel    indexed registers 2 and 3
//   pal_we, pal_idx, pal_data one-clock palette write strobe
//   blink                     blink phase
//   wait_state                wait-state FSM state
// ----------------------------------------------------------------------------
module video_ioregs
    import video_pkg::*;
#(
    parameter logic [15:0] IO_BASE_ADDR   = 16'h3D0,
    parameter int          IDX_BITS       = 5,
    parameter int          ENABLE_INDEXED = 1,
    parameter int          USE_BUS_WAIT   = 0,
    parameter int          WAIT_CYCLES    = 4,
    parameter logic [23:0] BLINK_MAX      = 24'd0
)(
    input  logic        clk,
    input  logic        reset_l,
    input  logic [14:0] bus_a,
    input  logic        bus_ior_l,
    input  logic        bus_iow_l,
    input  logic [7:0]  bus_d,
    input  logic        bus_aen,
    input  logic        hw_en,
    input  logic        vsync_l,
    input  logic        display_enable,
    input  logic        splashscreen,
    output logic [7:0]  bus_out,
    output logic        bus_dir,
    output logic        bus_rdy,
    output logic [7:0]  control_reg,
    output logic [7:0]  color_reg,
    output logic [3:0]  border_color,
    output logic [4:0]  mode_sel,
    output logic        pal_we,
    output logic [3:0]  pal_idx,
    output logic [3:0]  pal_data,
    output logic        blink,
    output wait_state_t wait_state
);

    localparam int DEPTH  = 1 << IDX_BITS;
    localparam bit IDX_EN = (ENABLE_INDEXED != 0);

    // ------------------------------------------------------------------
    // Strobe synchronisers with one extra history flop for edge detect.
    // History resets low, so a strobe already low when reset releases is
    // never mistaken for a fresh falling edge.
    // ------------------------------------------------------------------
    logic [2:0] iow_sync;
    logic [2:0] ior_sync;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            iow_sync <= 3'b000;
            ior_sync <= 3'b000;
        end else begin
            iow_sync <= {iow_sync[1:0], bus_iow_l};
            ior_sync <= {ior_sync[1:0], bus_ior_l};
        end
    end

    logic iow_fall;
    logic ior_fall;
    assign iow_fall = iow_sync[2] & ~iow_sync[1];
    assign ior_fall = ior_sync[2] & ~ior_sync[1];

    // ------------------------------------------------------------------
    // Address decode (shared by the read mux and the write path)
    // ------------------------------------------------------------------
    logic       base_hit;
    logic [3:0] ofs;
    logic       hit_ctrl, hit_color, hit_status, hit_idxdata;

    assign ofs         = bus_a[3:0];
    assign base_hit    = ~bus_aen & hw_en & (bus_a[14:4] == IO_BASE_ADDR[14:4]);
    assign hit_ctrl    = base_hit & (ofs == OFS_CTRL);
    assign hit_color   = base_hit & (ofs == OFS_COLOR);
    assign hit_status  = base_hit & (ofs == OFS_STATUS);
    assign hit_idxdata = base_hit & IDX_EN & (ofs == OFS_IDXDATA);

    logic wr_ctrl, wr_color, wr_index, wr_data;
    assign wr_ctrl  = iow_fall & hit_ctrl;
    assign wr_color = iow_fall & hit_color;
    // The status port doubles as the index register only on Tandy-style parts.
    assign wr_index = iow_fall & hit_status & IDX_EN;
    assign wr_data  = iow_fall & hit_idxdata;

    // ------------------------------------------------------------------
    // Register file and side-effect registers
    // ------------------------------------------------------------------
    logic [IDX_BITS-1:0] index;
    logic [7:0]          index_ext;
    logic [7:0]          regfile [DEPTH];

    assign index_ext = 8'(index);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            control_reg  <= CTRL_RESET;
            color_reg    <= 8'h00;
            index        <= '0;
            border_color <= 4'h0;
            mode_sel     <= 5'h00;
            pal_we       <= 1'b0;
            pal_idx      <= 4'h0;
            pal_data     <= 4'h0;
            for (int i = 0; i < DEPTH; i++) begin
                regfile[i] <= 8'h00;
            end
        end else begin
            pal_we <= 1'b0;
            if (wr_ctrl) begin
                control_reg <= bus_d;
            end
            if (wr_color) begin
                color_reg <= bus_d;
            end
            if (wr_index) begin
                index <= bus_d[IDX_BITS-1:0];
            end
            if (wr_data) begin
                regfile[index] <= bus_d;
                if (index_ext == REG_BORDER) begin
                    border_color <= bus_d[3:0];
                end
                if (index_ext == REG_MODESEL) begin
                    mode_sel <= bus_d[4:0];
                end
                if (is_pal_reg(index_ext)) begin
                    pal_we   <= 1'b1;
                    pal_idx  <= index_ext[3:0];
                    pal_data <= bus_d[3:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux, combinational from the raw read strobe
    // ------------------------------------------------------------------
    always_comb begin
        bus_out = 8'h00;
        bus_dir = 1'b0;
        if (!bus_ior_l) begin
            if (hit_status) begin
                bus_out = {4'hF, vsync_l, 2'b10, ~display_enable};
                bus_dir = 1'b1;
            end else if (hit_idxdata) begin
                bus_out = regfile[index];
                bus_dir = 1'b1;
            end else if (hit_ctrl | hit_color) begin
                // Write-only registers still claim the bus and read as zero.
                bus_dir = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Wait-state generation
    // ------------------------------------------------------------------
    logic access_start;
    logic strobes_idle;

    assign access_start = (iow_fall | ior_fall) &
                          (hit_ctrl | hit_color | hit_status | hit_idxdata);
    assign strobes_idle = iow_sync[1] & ior_sync[1];

    video_bus_wait #(
        .USE_BUS_WAIT (USE_BUS_WAIT),
        .WAIT_CYCLES  (WAIT_CYCLES)
    ) u_bus_wait (
        .clk          (clk),
        .reset_l      (reset_l),
        .start        (access_start),
        .strobes_idle (strobes_idle),
        .bus_rdy      (bus_rdy),
        .state        (wait_state)
    );

    // ------------------------------------------------------------------
    // Blink: toggles every BLINK_MAX+1 clocks, frozen during splash screen
    // ------------------------------------------------------------------
    logic [23:0] blink_cnt;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            blink_cnt <= 24'd0;
            blink     <= 1'b0;
        end else if (!splashscreen) begin
            if (blink_cnt == BLINK_MAX) begin
                blink_cnt <= 24'd0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + 24'd1;
            end
        end
    end

endmodule

// File: doc/video_ioregs.md
# video_ioregs

Parametrised ISA I/O register block for the PC video adapters (CGA, Tandy, MDA-style base). It decodes port accesses at a configurable base, holds the mode/colour registers and a Tandy-style indexed register file, and emits one-cycle palette-write strobes to the pixel pipeline. It also generates bus wait states and the character/cursor blink signal. It sits between the ISA bus and the CRTC/sequencer/pixel blocks inside the video top level.

## Interface
- IO_BASE_ADDR, 16'h3D0, port base (3D0 CGA/Tandy, 3B0 MDA)
- IDX_BITS, 5, index register width; indexed file depth = 2**IDX_BITS
- ENABLE_INDEXED, 1, 0 disables base+A writes and base+E accesses (pure CGA)
- USE_BUS_WAIT, 0, 1 enables wait-state generation
- WAIT_CYCLES, 4, clocks bus_rdy is held low per access (1..15)
- BLINK_MAX, 24'd0, blink half-period minus one, in clk cycles
- clk  in  1  video clock
- reset_l  in  1  asynchronous, active-low reset
- bus_a  in  15  ISA address
- bus_ior_l / bus_iow_l  in  1  ISA I/O strobes, asynchronous
- bus_d  in  8  write data
- bus_aen  in  1  DMA address enable; high blocks decode
- hw_en  in  1  adapter enabled; low blocks decode
- vsync_l, display_enable  in  1  CRTC status sources
- splashscreen  in  1  freezes blink counter
- bus_out  out  8  read data
- bus_dir  out  1  high while this block drives a read
- bus_rdy  out  1  ISA ready
- control_reg, color_reg  out  8  mode control (base+8), colour select (base+9)
- border_color  out  4; mode_sel  out  5  indexed regs 2 and 3
- pal_we  out  1; pal_idx  out  4; pal_data  out  4  palette write strobe
- blink  out  1  blink phase

## Operation
- Strobes pass through a 2-flop synchroniser; a write is the single clk where synced iow_l goes 1->0 (exactly one write per bus cycle; latched bus_a/bus_d sampled that cycle).
- Decode requires ~bus_aen & hw_en. base+8 -> control_reg; base+9 -> color_reg; base+A write -> index = bus_d[IDX_BITS-1:0]; base+E write -> indexed file[index].
- Indexed decode: 2 -> border_color = bus_d[3:0]; 3 -> mode_sel = bus_d[4:0]; 16..31 -> pal_we pulse, pal_idx = index[3:0], pal_data = bus_d[3:0]; all others stored in file only.
- Reads combinational from raw bus_ior_l: base+A returns {4'hF, vsync_l, 2'b10, ~display_enable}; base+E returns file[index]; base+8/9 return 8'h00 with bus_dir=1; otherwise bus_out=0, bus_dir=0.
- Wait FSM states IDLE, WAIT, HOLD: IDLE->WAIT on decoded synced strobe; WAIT counts WAIT_CYCLES then ->HOLD; HOLD->IDLE when both synced strobes high. bus_rdy=0 only in WAIT. USE_BUS_WAIT=0 forces bus_rdy=1.
- Blink: counter counts 0..BLINK_MAX; on match clears and toggles blink; holds while splashscreen=1.

## Timing
- Reset values: control_reg 8'h29, color_reg 0, index 0, file 0, border_color 0, mode_sel 0, pal_we 0, pal_idx 0, pal_data 0, blink 0, counter 0, bus_rdy 1, FSM IDLE.
- Write latency: register updates 3 clk after bus_iow_l falls (2 sync + edge); pal_we high exactly 1 clk.
- Index write and data write in consecutive bus cycles: data goes to the new index.
- Index wraps modulo 2**IDX_BITS; values above depth cannot occur.
- Strobe released during WAIT: FSM finishes count, passes HOLD, returns IDLE next clk.
- reset_l asserted mid-access: all state to reset values immediately; a still-low strobe after release does not produce a write (edge required).

## Structure
- Shared package video_pkg: port offset constants (CTRL 8, COLOR 9, STATUS A, IDXDATA E), indexed register numbers (BORDER 2, MODESEL 3, PAL_BASE 16), control_reg reset value, FSM state enum.
- One sub-module: video_bus_wait (wait-state FSM + counter).

## Test plan
- Reset, no access -> control_reg 8'h29, bus_rdy 1, blink 0, pal_we never high.
- iow to 3D8 data 8'h1A -> control_reg 8'h1A three clk after strobe fall; held strobe 20 clk -> single write.
- iow 3DA=8'h13, iow 3DE=8'h05 -> one pal_we pulse, pal_idx 3, pal_data 5; 3DA=8'h03, 3DE=8'h1F -> mode_sel 5'h1F.
- ior 3DA with vsync_l=0, display_enable=1 -> bus_out 8'hF4, bus_dir 1; ior 3DE after index 7 written 8'hA5 -> 8'hA5.
- USE_BUS_WAIT=1, WAIT_CYCLES=4, read 3DA -> bus_rdy low exactly 4 clk; aen=1 access -> bus_rdy stays 1, no write.
- BLINK_MAX=3 -> blink toggles every 4 clk; splashscreen=1 -> blink frozen.
